// File: rtl/apu_pulse.sv
// NES APU pulse channel: register snoop, 11-bit timer, duty sequencer,
// envelope and length counter, with a registered 4-bit sample output.
module apu_pulse (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       apu_cyc_in,
    input  logic       qtr_frame_in,
    input  logic       half_frame_in,
    input  logic       en_in,
    input  logic       wr_in,
    input  logic [1:0] a_in,
    input  logic [7:0] d_in,
    output logic [3:0] sample_out,
    output logic       active_out
);

    logic [1:0]  duty_q, duty_d;
    logic        halt_q, halt_d;
    logic        const_q, const_d;
    logic [3:0]  vol_q, vol_d;
    logic [10:0] period_q, period_d;
    logic [10:0] tmr_q, tmr_d;
    logic [2:0]  step_q, step_d;
    logic        env_start_q, env_start_d;
    logic [3:0]  decay_q, decay_d;
    logic [3:0]  div_q, div_d;
    logic [7:0]  len_q, len_d;
    logic [3:0]  sample_q, sample_d;
    logic        active_q, active_d;
    logic [7:0]  pattern;

    function automatic logic [7:0] len_lookup(input logic [4:0] idx);
        case (idx)
            5'd0:  len_lookup = 8'd10;   5'd1:  len_lookup = 8'd254;
            5'd2:  len_lookup = 8'd20;   5'd3:  len_lookup = 8'd2;
            5'd4:  len_lookup = 8'd40;   5'd5:  len_lookup = 8'd4;
            5'd6:  len_lookup = 8'd80;   5'd7:  len_lookup = 8'd6;
            5'd8:  len_lookup = 8'd160;  5'd9:  len_lookup = 8'd8;
            5'd10: len_lookup = 8'd60;   5'd11: len_lookup = 8'd10;
            5'd12: len_lookup = 8'd14;   5'd13: len_lookup = 8'd12;
            5'd14: len_lookup = 8'd26;   5'd15: len_lookup = 8'd14;
            5'd16: len_lookup = 8'd12;   5'd17: len_lookup = 8'd16;
            5'd18: len_lookup = 8'd24;   5'd19: len_lookup = 8'd18;
            5'd20: len_lookup = 8'd48;   5'd21: len_lookup = 8'd20;
            5'd22: len_lookup = 8'd96;   5'd23: len_lookup = 8'd22;
            5'd24: len_lookup = 8'd192;  5'd25: len_lookup = 8'd24;
            5'd26: len_lookup = 8'd72;   5'd27: len_lookup = 8'd26;
            5'd28: len_lookup = 8'd16;   5'd29: len_lookup = 8'd28;
            5'd30: len_lookup = 8'd32;   default: len_lookup = 8'd30;
        endcase
    endfunction

    // Bit n of the pattern is the waveform level at sequencer step n.
    always_comb begin
        case (duty_q)
            2'd0:    pattern = 8'b0000_0010;
            2'd1:    pattern = 8'b0000_0110;
            2'd2:    pattern = 8'b0001_1110;
            default: pattern = 8'b1111_1001;
        endcase
    end

    always_comb begin
        duty_d      = duty_q;
        halt_d      = halt_q;
        const_d     = const_q;
        vol_d       = vol_q;
        period_d    = period_q;
        tmr_d       = tmr_q;
        step_d      = step_q;
        env_start_d = env_start_q;
        decay_d     = decay_q;
        div_d       = div_q;
        len_d       = len_q;

        if (wr_in) begin
            case (a_in)
                2'd0: begin
                    duty_d  = d_in[7:6];
                    halt_d  = d_in[5];
                    const_d = d_in[4];
                    vol_d   = d_in[3:0];
                end
                2'd2:    period_d[7:0]  = d_in;
                2'd3:    period_d[10:8] = d_in[2:0];
                default: ;
            endcase
        end

        if (apu_cyc_in) begin
            if (tmr_q == 11'd0) begin
                tmr_d  = period_q;
                step_d = step_q + 3'd1;
            end else begin
                tmr_d = tmr_q - 11'd1;
            end
        end

        if (qtr_frame_in) begin
            if (env_start_q) begin
                env_start_d = 1'b0;
                decay_d     = 4'd15;
                div_d       = vol_q;
            end else if (div_q == 4'd0) begin
                div_d = vol_q;
                if (decay_q != 4'd0)
                    decay_d = decay_q - 4'd1;
                else if (halt_q)
                    decay_d = 4'd15;
            end else begin
                div_d = div_q - 4'd1;
            end
        end

        if (half_frame_in && len_q != 8'd0 && !halt_q)
            len_d = len_q - 8'd1;

        // Reg 3 side effects are applied last so they beat the strobe updates above.
        if (wr_in && a_in == 2'd3) begin
            step_d      = '0;
            env_start_d = 1'b1;
            if (en_in)
                len_d = len_lookup(d_in[7:3]);
        end

        if (!en_in)
            len_d = '0;
    end

    always_comb begin
        active_d = (len_q != 8'd0);
        if (len_q == 8'd0 || period_q < 11'd8 || !pattern[step_q])
            sample_d = '0;
        else
            sample_d = const_q ? vol_q : decay_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            duty_q      <= '0;
            halt_q      <= 1'b0;
            const_q     <= 1'b0;
            vol_q       <= '0;
            period_q    <= '0;
            tmr_q       <= '0;
            step_q      <= '0;
            env_start_q <= 1'b0;
            decay_q     <= '0;
            div_q       <= '0;
            len_q       <= '0;
            sample_q    <= '0;
            active_q    <= 1'b0;
        end else begin
            duty_q      <= duty_d;
            halt_q      <= halt_d;
            const_q     <= const_d;
            vol_q       <= vol_d;
            period_q    <= period_d;
            tmr_q       <= tmr_d;
            step_q      <= step_d;
            env_start_q <= env_start_d;
            decay_q     <= decay_d;
            div_q       <= div_d;
            len_q       <= len_d;
            sample_q    <= sample_d;
            active_q    <= active_d;
        end
    end

    assign sample_out = sample_q;
    assign active_out = active_q;

endmodule

// File: tb/tb_apu_pulse.sv
// Directed bench for apu_pulse: vector table for the square wave, plus
// hand sequences for length, envelope and coincident-event corners.
module tb_apu_pulse;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       apu = 1'b0;
    logic       qtr = 1'b0;
    logic       half = 1'b0;
    logic       en = 1'b0;
    logic       wr = 1'b0;
    logic [1:0] a = '0;
    logic [7:0] d = '0;
    logic [3:0] sample_out;
    logic       active_out;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    apu_pulse dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .apu_cyc_in   (apu),
        .qtr_frame_in (qtr),
        .half_frame_in(half),
        .en_in        (en),
        .wr_in        (wr),
        .a_in         (a),
        .d_in         (d),
        .sample_out   (sample_out),
        .active_out   (active_out)
    );

    typedef struct packed {
        logic       rst, en, apu, qtr, half, wr;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] n;
        logic       chk;
        logic [3:0] es;
        logic       ea;
    } vec_t;

    localparam int NV = 22;
    vec_t tv [0:NV-1];

    function automatic vec_t mk(input logic r, e, ap, q, h, w, input logic [1:0] aa,
                                input logic [7:0] dd, input logic [7:0] n,
                                input logic c, input logic [3:0] es, input logic ea);
        vec_t v;
        v.rst = r; v.en = e; v.apu = ap; v.qtr = q; v.half = h; v.wr = w;
        v.a = aa; v.d = dd; v.n = n; v.chk = c; v.es = es; v.ea = ea;
        return v;
    endfunction

    task automatic cyc(input logic r, e, ap, q, h, w, input logic [1:0] aa, input logic [7:0] dd);
        @(negedge clk);
        rst = r; en = e; apu = ap; qtr = q; half = h; wr = w; a = aa; d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic e);
        cyc(1'b0, e, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic wreg(input logic [1:0] aa, input logic [7:0] dd);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, aa, dd);
    endtask

    task automatic hstrobe();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic qstrobe();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic reset1();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        int m;
        logic [3:0] ed;

        //            rst en apu qtr hlf wr a  d      n  chk es ea
        tv[0]  = mk(1, 0, 1, 1, 1, 0, 0, 8'h00, 3, 1, 0,  0);
        tv[1]  = mk(0, 0, 1, 1, 1, 0, 0, 8'h00, 4, 1, 0,  0);
        tv[2]  = mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1, 0,  0);
        tv[3]  = mk(0, 1, 0, 0, 0, 1, 0, 8'hBF, 1, 1, 0,  0);
        tv[4]  = mk(0, 1, 0, 0, 0, 1, 2, 8'h08, 1, 1, 0,  0);
        tv[5]  = mk(0, 1, 0, 0, 0, 1, 3, 8'h08, 1, 1, 0,  0);
        tv[6]  = mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 1, 0,  1);
        tv[7]  = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 0,  1);
        tv[8]  = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 9, 1, 15, 1);
        tv[9]  = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 9, 1, 15, 1);
        tv[10] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 9, 1, 15, 1);
        tv[11] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 8, 1, 15, 1);
        tv[12] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 15, 1);
        tv[13] = mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 1, 0,  1);
        tv[14] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 9, 1, 0,  1);
        tv[15] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 9, 1, 0,  1);
        tv[16] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 9, 1, 0,  1);
        tv[17] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 9, 1, 0,  1);
        tv[18] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 9, 1, 15, 1);
        tv[19] = mk(0, 1, 0, 0, 0, 1, 2, 8'h07, 1, 1, 15, 1);
        tv[20] = mk(0, 1, 0, 0, 0, 1, 3, 8'h00, 1, 1, 0,  1);
        tv[21] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 20, 1, 0, 1);

        for (int i = 0; i < NV; i++) begin
            for (int r = 0; r < int'(tv[i].n); r++)
                cyc(tv[i].rst, tv[i].en, tv[i].apu, tv[i].qtr, tv[i].half, tv[i].wr, tv[i].a, tv[i].d);
            if (tv[i].chk) begin
                check($sformatf("vec%0d sample", i), {4'd0, sample_out}, {4'd0, tv[i].es});
                check($sformatf("vec%0d active", i), {7'd0, active_out}, {7'd0, tv[i].ea});
            end
        end

        // Length counter runs down with halt clear.
        reset1();
        wreg(2'd0, 8'h10);
        wreg(2'd3, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            hstrobe();
            check($sformatf("len_run%0d", k), {7'd0, active_out}, 8'd1);
        end
        idle(1'b1);
        check("len_expired", {7'd0, active_out}, 8'd0);
        check("len_expired_sample", {4'd0, sample_out}, 8'd0);

        // Halt freezes the count; releasing it shows the count was still 10.
        wreg(2'd0, 8'h30);
        wreg(2'd3, 8'h00);
        repeat (12) hstrobe();
        idle(1'b1);
        check("len_halt_hold", {7'd0, active_out}, 8'd1);
        wreg(2'd0, 8'h10);
        repeat (9) hstrobe();
        idle(1'b1);
        check("len_halt_9", {7'd0, active_out}, 8'd1);
        hstrobe();
        idle(1'b1);
        check("len_halt_10", {7'd0, active_out}, 8'd0);

        // Envelope decay, no loop: 15 on first quarter frame, then -1 every 3, stuck at 0.
        reset1();
        wreg(2'd0, 8'hC2);
        wreg(2'd2, 8'h08);
        wreg(2'd3, 8'h08);
        for (int k = 1; k <= 52; k++) begin
            qstrobe();
            idle(1'b1);
            m = (k - 1) / 3;
            ed = (m >= 15) ? 4'd0 : 4'(15 - m);
            check($sformatf("env_noloop%0d", k), {4'd0, sample_out}, {4'd0, ed});
        end

        // Envelope with loop: wraps 0 -> 15.
        reset1();
        wreg(2'd0, 8'hE2);
        wreg(2'd2, 8'h08);
        wreg(2'd3, 8'h08);
        for (int k = 1; k <= 55; k++) begin
            qstrobe();
            idle(1'b1);
            m = (k - 1) / 3;
            ed = 4'(15 - (m % 16));
            check($sformatf("env_loop%0d", k), {4'd0, sample_out}, {4'd0, ed});
        end

        // Enable dropped mid-note, then a reg 3 write while disabled.
        reset1();
        wreg(2'd0, 8'hDF);
        wreg(2'd2, 8'h08);
        wreg(2'd3, 8'h08);
        idle(1'b1);
        check("en_note_sample", {4'd0, sample_out}, 8'd15);
        check("en_note_active", {7'd0, active_out}, 8'd1);
        idle(1'b0);
        idle(1'b0);
        check("en_drop_active", {7'd0, active_out}, 8'd0);
        check("en_drop_sample", {4'd0, sample_out}, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'h08);
        idle(1'b1);
        check("en_low_write", {7'd0, active_out}, 8'd0);

        // Reg 3 load coincident with half frame: no decrement on the load clock.
        reset1();
        wreg(2'd0, 8'h10);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 8'h18);
        hstrobe();
        idle(1'b1);
        check("load_half_1", {7'd0, active_out}, 8'd1);
        hstrobe();
        idle(1'b1);
        check("load_half_2", {7'd0, active_out}, 8'd0);

        // Reset asserted mid-note, strobes active.
        reset1();
        wreg(2'd0, 8'hDF);
        wreg(2'd2, 8'h08);
        wreg(2'd3, 8'h08);
        idle(1'b1);
        check("rst_note_sample", {4'd0, sample_out}, 8'd15);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        check("rst_mid_sample", {4'd0, sample_out}, 8'd0);
        check("rst_mid_active", {7'd0, active_out}, 8'd0);
        idle(1'b1);
        check("rst_after_sample", {4'd0, sample_out}, 8'd0);
        check("rst_after_active", {7'd0, active_out}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
